bus_arbiter_mux: RTL and testbench
==================================

BUS_ARBITER_MUX -- requirements
Module: bus_arbiter_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 32, bus data width in bits.
REQ-002 SHALL have parameter NUM_SRC, default 32, number of bus sources (2..64).
REQ-003 SHALL have derived localparam SEL_W = clog2(NUM_SRC), default 5.
REQ-004 SHALL have port clock  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port clear_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port req  in  NUM_SRC  per-source bus request (one bit per source, e.g. R0out..in_31).
REQ-007 SHALL have port data_in  in  NUM_SRC*WIDTH  flattened source data, source i at bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port hold  in  1  keep the current grant while its owner still requests.
REQ-009 SHALL have port bus_out  out  WIDTH  registered bus value.
REQ-010 SHALL have port bus_valid  out  1  bus_out was driven by a grant this cycle.
REQ-011 SHALL have port grant_idx  out  SEL_W  index of the source that drove bus_out.
REQ-012 SHALL have port multi_req  out  1  registered flag: more than one req bit was high in the sampled cycle.

Function
REQ-013 SHALL sample req/data_in each rising edge and present the granted source's data on bus_out one cycle later (latency 1).
REQ-014 SHALL, when req is all-zero, drive bus_valid=0 and hold bus_out and grant_idx at their previous values.
REQ-015 SHALL grant exactly one source per cycle when any req bit is high; bus_valid=1 the following cycle.
REQ-016 SHALL, when hold=1 and the previously granted source still requests, re-grant that source regardless of priority.
REQ-017 SHALL, when hold=1 but the held source has dropped req, arbitrate normally that cycle.
REQ-018 SHALL keep a priority pointer ptr (SEL_W bits); after a grant to i, ptr becomes i+1, wrapping NUM_SRC-1 -> 0.
REQ-019 SHALL not advance ptr on idle cycles or on held re-grants.
REQ-020 SHALL ignore data_in of non-granted sources completely.
REQ-021 SHALL set multi_req=1 for one cycle per sampled cycle with popcount(req)>1, independent of hold.
REQ-022 SHALL, for NUM_SRC not a power of two, never produce grant_idx >= NUM_SRC.

Reset
REQ-023 SHALL, while clear_n=0, force bus_out=0, bus_valid=0, grant_idx=0, multi_req=0, ptr=0 and held-owner state cleared, asynchronously.
REQ-024 SHALL resume arbitration on the first rising edge after clear_n deasserts, with source 0 highest priority; a grant in flight at reset is discarded.

Configuration
REQ-025 SHALL, with macro BUS_ARB_ROUND_ROBIN_EN defined, use the rotating priority of REQ-018/019.
REQ-026 SHALL, without BUS_ARB_ROUND_ROBIN_EN, use fixed priority (lowest index wins), ptr removed, hold still honoured.

Structure
REQ-027 SHALL place default WIDTH/NUM_SRC constants and the clog2 select-width function in shared package bus_pkg.
REQ-028 SHALL implement the arbitration in one sub-module rr_priority_encoder (req, ptr -> one-hot grant, index, any); the data path stays in bus_arbiter_mux.

Verification
REQ-029 SHALL cover: reset with req=all ones, release -> first cycle bus_out=data_in[0], grant_idx=0, multi_req=1.
REQ-030 SHALL cover: req bits 3,7,31 held high 4 cycles (RR) -> grant_idx 3,7,31,3; pointer wraps 31->0.
REQ-031 SHALL cover: single req bit 5, data 0xDEADBEEF -> bus_out=0xDEADBEEF, bus_valid=1 exactly 1 cycle later, multi_req=0.
REQ-032 SHALL cover: hold=1 with req 2 and 9 held 3 cycles after grant to 2 -> grant_idx stays 2; drop req[2] -> next grant 9.
REQ-033 SHALL cover: req drops to zero after bus_out=0x12345678 -> bus_valid=0, bus_out stays 0x12345678.
REQ-034 SHALL cover: clear_n pulsed low mid-stream -> outputs 0 immediately; macro undefined build grants lowest index among req {4,6}.

Source files
------------

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus arbiter defaults and select-width helper
//
// Purpose : default data width / source count for the bus arbiter and the
//           clog2 function used to size source-index fields.
// Contents: BUS_WIDTH_DEF, BUS_NUM_SRC_DEF, clog2()
package bus_pkg;

    localparam int BUS_WIDTH_DEF   = 32;
    localparam int BUS_NUM_SRC_DEF = 32;

    // Width of an index able to address n items; never narrower than 1 bit
    // so a two-source arbiter still has a usable grant_idx port.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_priority_encoder.sv
// rtl/rr_priority_encoder.sv - rotating-start priority encoder for bus requests
//
// Purpose : picks the first requesting source at or after ptr_i, wrapping
//           past NUM_SRC-1 to 0. With ptr_i tied to 0 it degenerates into a
//           fixed lowest-index-wins encoder.
// Ports   : req_i       [NUM_SRC]  request vector
//           ptr_i       [SEL_W]    index of highest-priority source
//           grant_oh_o  [NUM_SRC]  one-hot winner (zero when nothing requests)
//           grant_idx_o [SEL_W]    binary winner index (zero when idle)
//           any_o                  at least one request present
module rr_priority_encoder
    import bus_pkg::*;
#(
    parameter int NUM_SRC = BUS_NUM_SRC_DEF,
    parameter int SEL_W   = clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [SEL_W-1:0]   ptr_i,
    output logic [NUM_SRC-1:0] grant_oh_o,
    output logic [SEL_W-1:0]   grant_idx_o,
    output logic               any_o
);

    always_comb begin
        int base;
        int cand;
        grant_oh_o  = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        cand        = 0;
        // An out-of-range pointer cannot arise from the top, but clamping it
        // keeps every candidate index inside req_i for odd NUM_SRC values.
        base        = (int'(ptr_i) < NUM_SRC) ? int'(ptr_i) : 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = base + k;
            if (cand >= NUM_SRC) begin
                cand = cand - NUM_SRC;
            end
            if (!any_o && req_i[cand]) begin
                any_o            = 1'b1;
                grant_idx_o      = SEL_W'(cand);
                grant_oh_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_mux.sv
// rtl/bus_arbiter_mux.sv - arbitrated N-source bus multiplexer with hold
//
// Purpose : samples NUM_SRC request/data pairs each clock, grants one source
//           and registers its data onto the bus (latency 1). hold keeps the
//           previous owner while it still requests.
// Config  : BUS_ARB_ROUND_ROBIN_EN defined   -> rotating priority pointer
//           BUS_ARB_ROUND_ROBIN_EN undefined -> fixed priority, lowest index wins
// Ports   : clock                    rising-edge clock
//           clear_n                  asynchronous active-low reset
//           req       [NUM_SRC]      per-source request
//           data_in   [NUM_SRC*WIDTH] source i at [i*WIDTH +: WIDTH]
//           hold                     keep current owner while it requests
//           bus_out   [WIDTH]        registered bus value
//           bus_valid                bus_out driven by a grant this cycle
//           grant_idx [SEL_W]        source that drove bus_out
//           multi_req                more than one request in sampled cycle
module bus_arbiter_mux
    import bus_pkg::*;
#(
    parameter int  WIDTH   = BUS_WIDTH_DEF,
    parameter int  NUM_SRC = BUS_NUM_SRC_DEF,
    localparam int SEL_W   = clog2(NUM_SRC)
) (
    input  logic                     clock,
    input  logic                     clear_n,
    input  logic [NUM_SRC-1:0]       req,
    input  logic [NUM_SRC*WIDTH-1:0] data_in,
    input  logic                     hold,
    output logic [WIDTH-1:0]         bus_out,
    output logic                     bus_valid,
    output logic [SEL_W-1:0]         grant_idx,
    output logic                     multi_req
);

    logic [WIDTH-1:0]   bus_out_q,   bus_out_d;
    logic               bus_valid_q, bus_valid_d;
    logic [SEL_W-1:0]   grant_idx_q, grant_idx_d;
    logic               multi_req_q, multi_req_d;

    logic [SEL_W-1:0]   ptr;
    logic [NUM_SRC-1:0] enc_oh;
    logic [SEL_W-1:0]   enc_idx;
    logic               enc_any;
    logic               hold_hit;
    logic [NUM_SRC-1:0] sel_oh;
    logic [SEL_W-1:0]   sel_idx;
    logic [WIDTH-1:0]   sel_data;

    rr_priority_encoder #(
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_enc (
        .req_i       (req),
        .ptr_i       (ptr),
        .grant_oh_o  (enc_oh),
        .grant_idx_o (enc_idx),
        .any_o       (enc_any)
    );

    // The owner is whoever drove the bus last cycle; an idle cycle means the
    // owner stopped requesting, so it no longer holds anything.
    assign hold_hit = hold && bus_valid_q && req[grant_idx_q];

    always_comb begin
        sel_oh  = enc_oh;
        sel_idx = enc_idx;
        if (hold_hit) begin
            sel_oh  = NUM_SRC'(1) << grant_idx_q;
            sel_idx = grant_idx_q;
        end
    end

    // AND-OR mux: only the granted source's slice can reach the bus.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            sel_data = sel_data | (data_in[i*WIDTH +: WIDTH] & {WIDTH{sel_oh[i]}});
        end
    end

`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic [SEL_W-1:0] ptr_q, ptr_d;

    // Pointer moves just past a freshly arbitrated winner; held re-grants and
    // idle cycles leave it alone.
    always_comb begin
        ptr_d = ptr_q;
        if (enc_any && !hold_hit) begin
            ptr_d = (enc_idx == SEL_W'(NUM_SRC - 1)) ? '0 : enc_idx + SEL_W'(1);
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    always_comb begin
        bus_out_d   = bus_out_q;
        grant_idx_d = grant_idx_q;
        bus_valid_d = enc_any;
        // x & (x-1) clears the lowest set bit; anything left means >1 request.
        multi_req_d = ((req & (req - NUM_SRC'(1))) != '0);
        if (enc_any) begin
            bus_out_d   = sel_data;
            grant_idx_d = sel_idx;
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            bus_out_q   <= '0;
            bus_valid_q <= 1'b0;
            grant_idx_q <= '0;
            multi_req_q <= 1'b0;
        end else begin
            bus_out_q   <= bus_out_d;
            bus_valid_q <= bus_valid_d;
            grant_idx_q <= grant_idx_d;
            multi_req_q <= multi_req_d;
        end
    end

    assign bus_out   = bus_out_q;
    assign bus_valid = bus_valid_q;
    assign grant_idx = grant_idx_q;
    assign multi_req = multi_req_q;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// tb/tb_bus_arbiter_mux.sv - scoreboard bench for bus_arbiter_mux
module tb_bus_arbiter_mux;

    localparam int W  = 32;
    localparam int NS = 32;
    localparam int SW = 5;

    logic              clock = 1'b0;
    logic              clear_n;
    logic [NS-1:0]     req;
    logic [NS*W-1:0]   data_in;
    logic              hold;
    logic [W-1:0]      bus_out;
    logic              bus_valid;
    logic [SW-1:0]     grant_idx;
    logic              multi_req;

    always #5 clock = ~clock;

    bus_arbiter_mux #(
        .WIDTH   (W),
        .NUM_SRC (NS)
    ) dut (
        .clock     (clock),
        .clear_n   (clear_n),
        .req       (req),
        .data_in   (data_in),
        .hold      (hold),
        .bus_out   (bus_out),
        .bus_valid (bus_valid),
        .grant_idx (grant_idx),
        .multi_req (multi_req)
    );

    typedef struct packed {
        logic          valid;
        logic [W-1:0]  data;
        logic [SW-1:0] idx;
        logic          multi;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference state: what the bus looked like after the last sampled cycle.
    int           m_ptr;
    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_idx;

    function automatic void model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_data  = '0;
        m_idx   = 0;
    endfunction

    function automatic logic [NS*W-1:0] rand_data();
        logic [NS*W-1:0] d;
        d = '0;
        for (int i = 0; i < NS; i++) begin
            d[i*W +: W] = $urandom;
        end
        return d;
    endfunction

    // Called at a falling edge: drives one cycle of stimulus, predicts the
    // bus state after the next rising edge and queues it for the monitor.
    task automatic apply(input logic [NS-1:0] r, input logic [NS*W-1:0] d, input logic h);
        exp_t e;
        int   g;
        logic found;
        req     = r;
        data_in = d;
        hold    = h;
        e.multi = ($countones(r) > 1);
        if (r == '0) begin
            e.valid = 1'b0;
            e.data  = m_data;
            e.idx   = SW'(m_idx);
            m_valid = 1'b0;
        end else begin
            found = 1'b0;
            g     = 0;
            if (h && m_valid && r[m_idx]) begin
                g     = m_idx;
                found = 1'b1;
            end else begin
                for (int k = 0; k < NS; k++) begin
                    if (!found && r[(m_ptr + k) % NS]) begin
                        g     = (m_ptr + k) % NS;
                        found = 1'b1;
                    end
                end
`ifdef BUS_ARB_ROUND_ROBIN_EN
                m_ptr = (g + 1) % NS;
`endif
            end
            m_valid = 1'b1;
            m_idx   = g;
            m_data  = d[g*W +: W];
            e.valid = 1'b1;
            e.data  = m_data;
            e.idx   = SW'(g);
        end
        exp_q.push_back(e);
        @(negedge clock);
    endtask

    task automatic check_zero(input string name);
        vectors++;
        if (bus_out !== '0 || bus_valid !== 1'b0 || grant_idx !== '0 || multi_req !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: got bus_out=%h valid=%b idx=%0d multi=%b, want all zero",
                     name, bus_out, bus_valid, grant_idx, multi_req);
        end
    endtask

    // Called at a falling edge; reset lands mid-cycle and any queued
    // prediction for the upcoming edge is dropped with the in-flight grant.
    task automatic pulse_reset(input int cycles);
        #2;
        clear_n = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        check_zero("async_reset");
        req     = '1;
        data_in = rand_data();
        hold    = 1'b0;
        repeat (cycles) @(negedge clock);
        check_zero("reset_held");
        clear_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if ({bus_valid, bus_out, grant_idx, multi_req} !== e) begin
                    miscompares++;
                    $display("FAIL bus_cycle @%0t: got valid=%b data=%h idx=%0d multi=%b, want valid=%b data=%h idx=%0d multi=%b",
                             $time, bus_valid, bus_out, grant_idx, multi_req,
                             e.valid, e.data, e.idx, e.multi);
                end
            end
        end
    end

    initial begin : stimulus
        logic [NS-1:0]   r;
        logic [NS-1:0]   prev_r;
        logic [NS*W-1:0] d;

        model_reset();
        clear_n = 1'b0;
        req     = '1;
        hold    = 1'b0;
        data_in = rand_data();
        @(negedge clock);
        check_zero("power_on_reset");
        repeat (2) @(negedge clock);
        clear_n = 1'b1;

        // All sources requesting on release: source 0 wins, multi_req set.
        apply('1, rand_data(), 1'b0);

        r = '0; r[3] = 1'b1; r[7] = 1'b1; r[31] = 1'b1;
        repeat (4) apply(r, rand_data(), 1'b0);

        d = rand_data();
        d[5*W +: W] = 32'hDEADBEEF;
        apply(NS'(1) << 5, d, 1'b0);
        apply(NS'(1) << 5, rand_data(), 1'b0);

        // Hold: owner 2 keeps the bus against 9 until it drops its request.
        apply(NS'(1) << 2, rand_data(), 1'b0);
        r = '0; r[2] = 1'b1; r[9] = 1'b1;
        repeat (3) apply(r, rand_data(), 1'b1);
        apply(NS'(1) << 9, rand_data(), 1'b1);
        apply(r, rand_data(), 1'b0);

        // Idle after a known bus value: value and index are retained.
        d = rand_data();
        d[11*W +: W] = 32'h12345678;
        apply(NS'(1) << 11, d, 1'b0);
        apply('0, rand_data(), 1'b0);
        apply('0, rand_data(), 1'b1);

        repeat (3) apply(NS'($urandom), rand_data(), 1'b0);
        pulse_reset(2);
        r = '0; r[4] = 1'b1; r[6] = 1'b1;
        apply(r, rand_data(), 1'b0);
        apply(r, rand_data(), 1'b0);

        prev_r = r;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 4))
                0:       r = '0;
                1:       r = NS'(1) << $urandom_range(0, NS - 1);
                2:       r = NS'($urandom & $urandom & $urandom);
                3:       r = prev_r;
                default: r = NS'($urandom);
            endcase
            apply(r, rand_data(), 1'($urandom_range(0, 1)));
            prev_r = r;
            if (n == 200) begin
                pulse_reset(1);
            end
        end

        repeat (3) @(negedge clock);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending predictions, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
